// File: rtl/answer_sequencer.sv
// answer_sequencer: steps the LCG generator on each new-answer request,
// screens the returned value (1..8, not equal to the previous answer) and
// writes the accepted answer with a one-cycle write_enable. When too many
// samples are rejected, a forced answer (previous + 1, wrapping) is written.
`timescale 1ns/1ps
module answer_sequencer #(
    parameter int RNG_LAT   = 1,
    parameter int MAX_RETRY = 3,
    parameter int ANS_MIN   = 1,
    parameter int ANS_MAX   = 8
) (
    input  logic        clk50M,
    input  logic        rst,
    input  logic        change_answer,
    input  logic [31:0] rng_value,
    output logic        rng_step,
    output logic [3:0]  answer,
    output logic        write_enable,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_STEP, S_WAIT, S_CHECK, S_WRITE} state_t;

    // WAIT lasts RNG_LAT-1 cycles: the counter loads RNG_LAT-2 and runs down to 0
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int WW = (RNG_LAT > 2) ? $clog2(RNG_LAT - 1) : 1;

    localparam logic [WW-1:0] WAIT_INIT = WW'((RNG_LAT > 1) ? RNG_LAT - 2 : 0);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
    localparam logic [31:0]   MIN32     = 32'(ANS_MIN);
    localparam logic [31:0]   MAX32     = 32'(ANS_MAX);
    localparam logic [3:0]    MIN4      = 4'(ANS_MIN);
    localparam logic [3:0]    MAX4      = 4'(ANS_MAX);

    state_t          state_q, state_d;
    logic            chg_q;
    logic [RW-1:0]   retry_q, retry_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            pending_q, pending_d;
    logic [3:0]      cand_d;
    logic [3:0]      answer_q, answer_d;
    logic            rng_step_q, rng_step_d;
    logic            we_q, we_d;
    logic            busy_q, busy_d;

    logic            req;
    logic            accept;
    logic [3:0]      fallback;

    // answer_q doubles as the previous answer: both always receive the same value
    assign req      = change_answer & ~chg_q;
    assign accept   = (rng_value >= MIN32) && (rng_value <= MAX32) &&
                      (rng_value != {28'd0, answer_q});
    assign fallback = (answer_q == MAX4) ? MIN4 : answer_q + 4'd1;

    // State and sequencing registers
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            chg_q     <= 1'b0;
            retry_q   <= '0;
            wait_q    <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            chg_q     <= change_answer;
            retry_q   <= retry_d;
            wait_q    <= wait_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic, retry/wait counters and the request queue (1 deep)
    always_comb begin
        state_d   = state_q;
        retry_d   = retry_q;
        wait_d    = wait_q;
        pending_d = pending_q;
        cand_d    = answer_q;
        if (req && state_q != S_IDLE && state_q != S_WRITE)
            pending_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_STEP;
                    retry_d = '0;
                end
            end
            S_STEP: begin
                if (RNG_LAT > 1) begin
                    state_d = S_WAIT;
                    wait_d  = WAIT_INIT;
                end else begin
                    state_d = S_CHECK;
                end
            end
            S_WAIT: begin
                if (wait_q == '0) state_d = S_CHECK;
                else              wait_d  = wait_q - WW'(1);
            end
            S_CHECK: begin
                if (accept) begin
                    state_d = S_WRITE;
                    cand_d  = rng_value[3:0];
                end else if (retry_q == RETRY_LIM) begin
                    state_d = S_WRITE;
                    cand_d  = fallback;
                end else begin
                    state_d = S_STEP;
                    retry_d = retry_q + RW'(1);
                end
            end
            S_WRITE: begin
                pending_d = 1'b0;
                if (pending_q || req) begin
                    state_d = S_STEP;
                    retry_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so every output is a flop aligned with its state
    always_comb begin
        rng_step_d = (state_d == S_STEP);
        we_d       = (state_d == S_WRITE);
        busy_d     = (state_d != S_IDLE);
        answer_d   = (state_d == S_WRITE) ? cand_d : answer_q;
    end

    // Output registers
    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            rng_step_q <= 1'b0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            answer_q   <= MIN4;
        end else begin
            rng_step_q <= rng_step_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            answer_q   <= answer_d;
        end
    end

    assign rng_step     = rng_step_q;
    assign answer       = answer_q;
    assign write_enable = we_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_answer_sequencer.sv
// Directed bench for answer_sequencer: one instance with RNG_LAT=1, one with RNG_LAT=4.
`timescale 1ns/1ps
module tb_answer_sequencer;

    logic        clk50M = 1'b0;
    logic        rst;
    logic        change_answer;
    logic [31:0] rng_value;
    logic        step1, we1, busy1;
    logic [3:0]  ans1;
    logic        step4, we4, busy4;
    logic [3:0]  ans4;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rv_q[$];
    logic [31:0] stp, wem, bsy, acc;

    always #10 clk50M = ~clk50M;

    answer_sequencer #(.RNG_LAT(1)) dut (
        .clk50M(clk50M), .rst(rst), .change_answer(change_answer), .rng_value(rng_value),
        .rng_step(step1), .answer(ans1), .write_enable(we1), .busy(busy1)
    );

    answer_sequencer #(.RNG_LAT(4)) dut4 (
        .clk50M(clk50M), .rst(rst), .change_answer(change_answer), .rng_value(rng_value),
        .rng_step(step4), .answer(ans4), .write_enable(we4), .busy(busy4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk50M);
        #1;
    endtask

    // ca_map bit c = change_answer level during cycle C0+c; bit c of the
    // returned maps = output seen during C0+c. The generator advances on each step.
    task automatic run_req(input bit sel4, input logic [31:0] ca_map, input int ncyc,
                           output logic [31:0] s_map, output logic [31:0] w_map,
                           output logic [31:0] b_map);
        logic s;
        s_map = '0; w_map = '0; b_map = '0;
        change_answer = ca_map[0];
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            change_answer = ca_map[c];
            s = sel4 ? step4 : step1;
            s_map[c] = s;
            w_map[c] = sel4 ? we4 : we1;
            b_map[c] = sel4 ? busy4 : busy1;
            if (s && rv_q.size() != 0) rng_value = rv_q.pop_front();
        end
        change_answer = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        rst = 1'b0;
        change_answer = 1'b0;
        rng_value = '0;
        #1;
        do_reset();
        chk("rst_ans",  ans1,  4'd1);
        chk("rst_we",   we1,   1'b0);
        chk("rst_busy", busy1, 1'b0);
        chk("rst_step", step1, 1'b0);

        // plain accept, prev=1 -> 5
        rv_q = '{32'd5};
        run_req(0, 32'h1, 6, stp, wem, bsy);
        chk("c2_step", stp, 32'h2);
        chk("c2_we",   wem, 32'h8);
        chk("c2_busy", bsy, 32'hE);
        chk("c2_ans",  ans1, 4'd5);

        // repeat of previous answer rejected once, prev=5 -> 7
        rv_q = '{32'd5, 32'd7};
        run_req(0, 32'h1, 8, stp, wem, bsy);
        chk("c3_step", stp, 32'hA);
        chk("c3_we",   wem, 32'h20);
        chk("c3_busy", bsy, 32'h3E);
        chk("c3_ans",  ans1, 4'd7);

        // upper bits set must reject even though low nibble is legal
        rv_q = '{32'h1000_0003, 32'd3};
        run_req(0, 32'h1, 8, stp, wem, bsy);
        chk("hi_step", stp, 32'hA);
        chk("hi_we",   wem, 32'h20);
        chk("hi_ans",  ans1, 4'd3);

        // 0 below range rejected, 8 (top of range) accepted
        rv_q = '{32'd0, 32'd8};
        run_req(0, 32'h1, 8, stp, wem, bsy);
        chk("lo_step", stp, 32'hA);
        chk("lo_we",   wem, 32'h20);
        chk("lo_ans",  ans1, 4'd8);

        // stuck at 9: 4 steps then forced 8+1 wraps to 1
        rv_q = '{32'd9, 32'd9, 32'd9, 32'd9};
        rng_value = 32'd9;
        run_req(0, 32'h1, 12, stp, wem, bsy);
        chk("c4_step", stp, 32'hAA);
        chk("c4_we",   wem, 32'h200);
        chk("c4_busy", bsy, 32'h3FE);
        chk("c4_ans",  ans1, 4'd1);

        // level held 8 cycles counts once; 1 == prev rejected, 2 accepted
        rv_q = '{32'd1, 32'd2};
        run_req(0, 32'hFF, 10, stp, wem, bsy);
        chk("hold_step", stp, 32'hA);
        chk("hold_we",   wem, 32'h20);
        chk("hold_ans",  ans1, 4'd2);

        // request arriving in the WRITE cycle chains straight into STEP
        rv_q = '{32'd3, 32'd4};
        run_req(0, 32'h9, 9, stp, wem, bsy);
        chk("wr_step", stp, 32'h12);
        chk("wr_we",   wem, 32'h48);
        chk("wr_ans",  ans1, 4'd4);

        // two extra edges during one busy period collapse to one more operation
        rv_q = '{32'd4, 32'd2, 32'd5};
        run_req(0, 32'h15, 12, stp, wem, bsy);
        chk("c5_step", stp, 32'h4A);
        chk("c5_we",   wem, 32'h120);
        chk("c5_busy", bsy, 32'h1FE);
        chk("c5_ans",  ans1, 4'd5);

        // RNG_LAT=4: reset in the WAIT window aborts the operation
        do_reset();
        rv_q = '{32'd6};
        change_answer = 1'b1;
        tick();
        change_answer = 1'b0;
        chk("c6_step", step4, 1'b1);
        if (step4 && rv_q.size() != 0) rng_value = rv_q.pop_front();
        tick();
        tick();
        chk("c6_busy_wait", busy4, 1'b1);
        rst = 1'b1;
        #1;
        chk("c6_rst_busy", busy4, 1'b0);
        chk("c6_rst_ans",  ans4,  4'd1);
        chk("c6_rst_we",   we4,   1'b0);
        chk("c6_rst_step", step4, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        acc = '0;
        for (int c = 0; c < 8; c++) begin
            tick();
            acc[c] = we4 | busy4;
        end
        chk("c6_quiet", acc, 32'h0);

        // fresh request after the abort: write at C0+2+L
        rv_q = '{32'd5};
        run_req(1, 32'h1, 10, stp, wem, bsy);
        chk("c6_step2", stp, 32'h2);
        chk("c6_we2",   wem, 32'h40);
        chk("c6_busy2", bsy, 32'h7E);
        chk("c6_ans2",  ans4, 4'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
